can_wb_master: RTL and testbench
================================

CAN_WB_MASTER -- requirements
Module: can_wb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the maximum number of cycles a bus cycle waits for acknowledge (legal range 1..255).
REQ-002 SHALL have parameter IR_ADDR, default 8'h03, meaning the interrupt-register address read automatically on interrupt.
REQ-003 SHALL have clk_i, input, 1, the single clock, with all logic rising-edge triggered.
REQ-004 SHALL have rst_in, input, 1, asynchronous active-low reset: assertion is asynchronous, release is synchronous to clk_i.
REQ-005 SHALL have the command inputs: cmd_valid_i 1; cmd_we_i 1 (1 = write); cmd_addr_i 8; cmd_wdata_i 8.
REQ-006 SHALL have cmd_ready_o, output, 1, meaning a command is accepted on cmd_valid_i && cmd_ready_o.
REQ-007 SHALL have the response outputs: rsp_valid_o 1; rsp_rdata_o 8; rsp_err_o 1 (timeout); rsp_irq_o 1 (response is an automatic IR read).
REQ-008 SHALL have rsp_ready_i, input, 1, meaning the response is consumed on rsp_valid_o && rsp_ready_i.
REQ-009 SHALL have irq_in, input, 1, the active-low, level, asynchronous interrupt from the CAN controller.
REQ-010 SHALL have the Wishbone classic initiator ports: wbm_cyc_o, wbm_stb_o, wbm_we_o (outputs, 1 each); wbm_adr_o 8 out; wbm_dat_o 8 out; wbm_dat_i 8 in; wbm_ack_i 1 in.

Function
REQ-011 SHALL synchronise irq_in through two flops; irq_req = synced irq low && irq_armed.
REQ-012 SHALL implement the FSM IDLE -> BUS -> RESP -> IDLE, with all Wishbone and response outputs registered.
REQ-013 In IDLE, irq_req SHALL take priority: load adr=IR_ADDR, we=0, src=irq, clear irq_armed, go to BUS; cmd_ready_o=0 that cycle.
REQ-014 cmd_ready_o SHALL be 1 only in IDLE with irq_req=0; on accept, latch we/addr/wdata with src=cmd and go to BUS.
REQ-015 In BUS, cyc/stb SHALL be 1; adr, dat_o and we SHALL be stable; cyc/stb SHALL first be high the cycle after accept.
REQ-016 On wbm_ack_i in BUS, SHALL capture wbm_dat_i into rsp_rdata_o (forced 0 for writes), set err=0, drop cyc/stb the next cycle and enter RESP.
REQ-017 The timeout counter SHALL clear on BUS entry and increment each BUS cycle without ack; at count == TIMEOUT_CYCLES without ack, SHALL enter RESP with err=1, rdata=0, and cyc/stb low.
REQ-018 If ack arrives in the same cycle the timeout expires, ack SHALL win (err=0).
REQ-019 wbm_ack_i outside BUS SHALL be ignored.
REQ-020 In RESP, rsp_valid_o SHALL be 1 with rdata/err/irq held stable until rsp_ready_i, then return to IDLE.
REQ-021 SHALL have latency accept at N, cyc at N+1, ack at N+k gives rsp_valid_o at N+k+1; back-to-back throughput SHALL be one transaction per k+2 cycles.
REQ-022 irq_armed SHALL be set whenever the synced irq is high, so an irq held low causes exactly one automatic read until it deasserts.
REQ-023 An irq arriving during a command transaction SHALL be serviced in the next IDLE, before any new command.

Reset
REQ-024 While rst_in=0: state IDLE; cyc/stb/we=0; adr/dat_o=0; cmd_ready_o=0; rsp_valid_o/err/irq=0; rsp_rdata_o=0; counter=0; sync flops=1; irq_armed=1.
REQ-025 Reset mid-BUS or mid-RESP SHALL drop cyc/stb and rsp_valid_o immediately, with no response emitted afterwards.
REQ-026 cmd_ready_o SHALL first go to 1 the first cycle after rst_in deasserts.

Verification
REQ-027 Write 0x5A to 0x04, with ack on the 2nd BUS cycle -> adr=0x04, dat_o=0x5A, we=1 for 2 cycles; rsp_valid with err=0, rdata=0x00.
REQ-028 Read 0x02 with dat_i=0xC3 and ack on the 1st BUS cycle -> rsp_valid at N+2, rdata=0xC3, err=0, irq=0.
REQ-029 No ack, TIMEOUT_CYCLES=16 -> cyc high exactly 16 cycles; rsp err=1, rdata=0x00.
REQ-030 irq_in low for 50 cycles with a command pending -> IR read of 0x03 first (rsp_irq_o=1), then the command; exactly one IR read.
REQ-031 rsp_ready_i held low for 10 cycles -> rsp_valid_o and data stable, cmd_ready_o=0 throughout.
REQ-032 rst_in pulsed low on the 3rd BUS cycle -> cyc/stb 0 asynchronously; no rsp_valid_o; cmd_ready_o=1 the cycle after release.

Source files
------------

// File: rtl/can_wb_master.sv
// Wishbone classic initiator for a CAN controller: single-beat command transactions plus an
// automatic interrupt-register read whenever the active-low irq line is seen asserted.
module can_wb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [7:0]  IR_ADDR        = 8'h03
) (
  input  logic       clk_i,
  input  logic       rst_in,
  input  logic       cmd_valid_i,
  input  logic       cmd_we_i,
  input  logic [7:0] cmd_addr_i,
  input  logic [7:0] cmd_wdata_i,
  output logic       cmd_ready_o,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_rdata_o,
  output logic       rsp_err_o,
  output logic       rsp_irq_o,
  input  logic       rsp_ready_i,
  input  logic       irq_in,
  output logic       wbm_cyc_o,
  output logic       wbm_stb_o,
  output logic       wbm_we_o,
  output logic [7:0] wbm_adr_o,
  output logic [7:0] wbm_dat_o,
  input  logic [7:0] wbm_dat_i,
  input  logic       wbm_ack_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  localparam logic [7:0] LP_TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t     r_state;
  logic       r_irq_s1;
  logic       r_irq_s2;
  logic       r_irq_armed;
  logic       r_run;
  logic       r_src;
  logic [7:0] r_cnt;
  logic       w_irq_req;
  logic       w_timeout;

  assign w_irq_req   = ~r_irq_s2 & r_irq_armed;
  // r_run holds ready low for the first cycle after reset release
  assign cmd_ready_o = r_run & (r_state == S_IDLE) & ~w_irq_req;
  // r_cnt counts completed BUS cycles, so the last allowed cycle sees TIMEOUT_CYCLES-1
  assign w_timeout   = (r_cnt == LP_TO_LAST);

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_irq_s1 <= 1'b1;
      r_irq_s2 <= 1'b1;
    end else begin
      r_irq_s1 <= irq_in;
      r_irq_s2 <= r_irq_s1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      r_state     <= S_IDLE;
      r_run       <= 1'b0;
      r_irq_armed <= 1'b1;
      r_src       <= 1'b0;
      r_cnt       <= 8'h00;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_adr_o   <= 8'h00;
      wbm_dat_o   <= 8'h00;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= 8'h00;
      rsp_err_o   <= 1'b0;
      rsp_irq_o   <= 1'b0;
    end else begin
      r_run <= 1'b1;
      if (r_irq_s2) r_irq_armed <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (r_run && w_irq_req) begin
            wbm_adr_o   <= IR_ADDR;
            wbm_we_o    <= 1'b0;
            wbm_dat_o   <= 8'h00;
            r_src       <= 1'b1;
            r_irq_armed <= 1'b0;
            r_cnt       <= 8'h00;
            wbm_cyc_o   <= 1'b1;
            wbm_stb_o   <= 1'b1;
            r_state     <= S_BUS;
          end else if (cmd_ready_o && cmd_valid_i) begin
            wbm_adr_o <= cmd_addr_i;
            wbm_we_o  <= cmd_we_i;
            wbm_dat_o <= cmd_wdata_i;
            r_src     <= 1'b0;
            r_cnt     <= 8'h00;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
            r_state   <= S_BUS;
          end
        end
        S_BUS: begin
          // ack is tested first so it wins over a timeout in the same cycle
          if (wbm_ack_i) begin
            rsp_rdata_o <= wbm_we_o ? 8'h00 : wbm_dat_i;
            rsp_err_o   <= 1'b0;
            rsp_irq_o   <= r_src;
            rsp_valid_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            rsp_rdata_o <= 8'h00;
            rsp_err_o   <= 1'b1;
            rsp_irq_o   <= r_src;
            rsp_valid_o <= 1'b1;
            wbm_cyc_o   <= 1'b0;
            wbm_stb_o   <= 1'b0;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_can_wb_master.sv
// Randomized bench for can_wb_master: a behavioural Wishbone target plus a transaction-level
// expectation of bus duration, response data, error and irq flags.
module tb_can_wb_master;
  localparam int         T   = 16;
  localparam logic [7:0] IRA = 8'h03;

  logic       clk_i = 1'b0;
  logic       rst_in = 1'b0;
  logic       cmd_valid_i = 1'b0, cmd_we_i = 1'b0;
  logic [7:0] cmd_addr_i = 8'h00, cmd_wdata_i = 8'h00;
  logic       cmd_ready_o;
  logic       rsp_valid_o, rsp_err_o, rsp_irq_o;
  logic [7:0] rsp_rdata_o;
  logic       rsp_ready_i = 1'b0;
  logic       irq_in = 1'b1;
  logic       wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [7:0] wbm_adr_o, wbm_dat_o;
  logic [7:0] wbm_dat_i = 8'h00;
  logic       wbm_ack_i = 1'b0;

  int checks = 0;
  int errors = 0;

  can_wb_master #(.TIMEOUT_CYCLES(T), .IR_ADDR(IRA)) dut (
    .clk_i(clk_i), .rst_in(rst_in),
    .cmd_valid_i(cmd_valid_i), .cmd_we_i(cmd_we_i), .cmd_addr_i(cmd_addr_i),
    .cmd_wdata_i(cmd_wdata_i), .cmd_ready_o(cmd_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
    .rsp_irq_o(rsp_irq_o), .rsp_ready_i(rsp_ready_i), .irq_in(irq_in),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Hold cmd_valid until the handshake is seen, then release it after the accepting edge.
  task automatic wait_acc();
    int n;
    n = 0;
    while (!cmd_ready_o && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    chk("acc_wait", (n < 100), 1);
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
    chk("cyc_after_acc", wbm_cyc_o, 1);
  endtask

  task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d);
    cmd_we_i = we; cmd_addr_i = a; cmd_wdata_i = d; cmd_valid_i = 1'b1;
    wait_acc();
  endtask

  // Act as the Wishbone target for one transaction: ack on BUS cycle k (0 = never),
  // then stall the response for 'hold' cycles before consuming it.
  task automatic serve(input logic we, input logic [7:0] adr, input logic [7:0] dat,
                       input logic irq, input int k, input logic [7:0] rd, input int hold);
    int n, cyc_n, e_n;
    logic [7:0] e_rd;
    logic e_err;
    bit stable;
    if (k >= 1 && k <= T) begin
      e_n = k; e_err = 1'b0; e_rd = we ? 8'h00 : rd;
    end else begin
      e_n = T; e_err = 1'b1; e_rd = 8'h00;
    end
    n = 0;
    while (!wbm_cyc_o && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk("bus_start", wbm_cyc_o, 1);
    chk("bus_adr", wbm_adr_o, adr);
    chk("bus_we", wbm_we_o, we);
    if (!irq) chk("bus_dat", wbm_dat_o, dat);
    cyc_n = 0; stable = 1'b1;
    while (wbm_cyc_o && cyc_n < T + 8) begin
      cyc_n++;
      if (!wbm_stb_o || wbm_adr_o !== adr || wbm_we_o !== we || (!irq && wbm_dat_o !== dat)
          || cmd_ready_o || rsp_valid_o) stable = 1'b0;
      if (cyc_n == k) begin
        wbm_ack_i = 1'b1; wbm_dat_i = rd;
      end else begin
        wbm_ack_i = 1'b0; wbm_dat_i = 8'($urandom);
      end
      @(negedge clk_i);
    end
    wbm_ack_i = 1'b0;
    chk("bus_stable", stable, 1);
    chk("cyc_len", cyc_n, e_n);
    chk("stb_low", wbm_stb_o, 0);
    chk("rsp_valid", rsp_valid_o, 1);
    chk("rsp_rdata", rsp_rdata_o, e_rd);
    chk("rsp_err", rsp_err_o, e_err);
    chk("rsp_irq", rsp_irq_o, irq);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      wbm_ack_i = 1'($urandom);
      @(negedge clk_i);
      if (!rsp_valid_o || rsp_rdata_o !== e_rd || rsp_err_o !== e_err || rsp_irq_o !== irq
          || cmd_ready_o || wbm_cyc_o) stable = 1'b0;
    end
    wbm_ack_i = 1'b0;
    chk("rsp_hold", stable, 1);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk("rsp_done", rsp_valid_o, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic we;
    logic [7:0] a, d, rd;
    int k, h, cnt;
    repeat (2) @(negedge clk_i);
    chk("rst_cyc", wbm_cyc_o, 0);
    chk("rst_stb", wbm_stb_o, 0);
    chk("rst_we", wbm_we_o, 0);
    chk("rst_adr", wbm_adr_o, 0);
    chk("rst_dat", wbm_dat_o, 0);
    chk("rst_rdy", cmd_ready_o, 0);
    chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_irq_o, rsp_rdata_o}, 0);
    rst_in = 1'b1;
    #1 chk("rdy_before_edge", cmd_ready_o, 0);
    @(negedge clk_i);
    chk("rdy_after_rst", cmd_ready_o, 1);

    issue(1'b1, 8'h04, 8'h5A); serve(1'b1, 8'h04, 8'h5A, 1'b0, 2, 8'hEE, 0);
    issue(1'b0, 8'h02, 8'h00); serve(1'b0, 8'h02, 8'h00, 1'b0, 1, 8'hC3, 0);
    issue(1'b0, 8'h11, 8'h00); serve(1'b0, 8'h11, 8'h00, 1'b0, 0, 8'hAB, 1);
    issue(1'b0, 8'h22, 8'h00); serve(1'b0, 8'h22, 8'h00, 1'b0, T, 8'h99, 0);
    issue(1'b0, 8'h33, 8'h00); serve(1'b0, 8'h33, 8'h00, 1'b0, 3, 8'h5C, 10);

    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); a = 8'($urandom); d = 8'($urandom); rd = 8'($urandom);
      k = $urandom_range(0, T + 2); h = $urandom_range(0, 3);
      issue(we, a, d);
      serve(we, a, d, 1'b0, k, rd, h);
    end

    // irq held low with a command pending: one IR read first, then the command
    irq_in = 1'b0;
    @(negedge clk_i); @(negedge clk_i);
    chk("irq_blocks_rdy", cmd_ready_o, 0);
    cmd_we_i = 1'b1; cmd_addr_i = 8'h40; cmd_wdata_i = 8'h81; cmd_valid_i = 1'b1;
    serve(1'b0, IRA, 8'h00, 1'b1, 2, 8'h27, 1);
    wait_acc();
    serve(1'b1, 8'h40, 8'h81, 1'b0, 3, 8'h00, 0);
    cnt = 0;
    repeat (30) begin
      @(negedge clk_i);
      if (wbm_cyc_o) cnt++;
    end
    chk("irq_once", cnt, 0);
    irq_in = 1'b1;
    repeat (4) @(negedge clk_i);

    // irq arriving mid-command is serviced before the next command
    issue(1'b0, 8'h50, 8'h00);
    irq_in = 1'b0;
    serve(1'b0, 8'h50, 8'h00, 1'b0, 5, 8'h6D, 0);
    cmd_we_i = 1'b0; cmd_addr_i = 8'h51; cmd_wdata_i = 8'h00; cmd_valid_i = 1'b1;
    serve(1'b0, IRA, 8'h00, 1'b1, 0, 8'h00, 0);
    wait_acc();
    serve(1'b0, 8'h51, 8'h00, 1'b0, 1, 8'hB4, 2);
    irq_in = 1'b1;
    repeat (4) @(negedge clk_i);

    // reset asserted during the third BUS cycle
    issue(1'b1, 8'h10, 8'h77);
    @(negedge clk_i); @(negedge clk_i);
    chk("pre_rst_cyc", wbm_cyc_o, 1);
    #2 rst_in = 1'b0;
    #1;
    chk("arst_cyc", wbm_cyc_o, 0);
    chk("arst_stb", wbm_stb_o, 0);
    chk("arst_rsp", rsp_valid_o, 0);
    chk("arst_rdy", cmd_ready_o, 0);
    @(negedge clk_i);
    rst_in = 1'b1;
    #1 chk("rel_rdy0", cmd_ready_o, 0);
    @(negedge clk_i);
    chk("rel_rdy1", cmd_ready_o, 1);
    cnt = 0;
    repeat (6) begin
      @(negedge clk_i);
      if (rsp_valid_o || wbm_cyc_o) cnt++;
    end
    chk("no_rsp_after_rst", cnt, 0);

    issue(1'b0, 8'h7E, 8'h00); serve(1'b0, 8'h7E, 8'h00, 1'b0, 2, 8'h3C, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
